uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Two-client byte scheduler in front of the UART transmit serializer. It accepts bytes from two independent valid/ready sources, arbitrates round-robin into a shared FIFO, and drains the FIFO into the serializer using its edge-triggered enable / busy protocol, one byte at a time. Typical clients: client 0 = CPU MMIO console writes, client 1 = debug/trace byte stream.

## Interface
- FIFO_AW, 4: FIFO address width; depth = 2**FIFO_AW entries.
- LAUNCH_TO, 16: max cycles in LAUNCH waiting for busy before abort; ≥4.
- GAP_CYC, 2: cycles uart_en held low after busy falls before the next launch; ≥2.
- sys_clk  in  1  clock; all logic on its rising edge.
- sys_rst_n  in  1  reset: asynchronous, active-low.
- s0_valid  in  1  client 0 byte offered.
- s0_data  in  8  client 0 byte.
- s0_ready  out  1  client 0 byte accepted this cycle (transfer = valid & ready).
- s1_valid / s1_data / s1_ready: same for client 1.
- uart_tx_busy  in  1  serializer busy (frame in progress).
- err_clr  in  1  one-cycle pulse; clears launch_err.
- uart_en  out  1  serializer enable; serializer starts a frame on its rising edge.
- uart_din  out  8  byte to serializer.
- fifo_count  out  FIFO_AW+1  current FIFO occupancy.
- idle  out  1  FIFO empty and FSM in IDLE.
- launch_err  out  1  sticky: a launch timed out.

## Operation
- Arbitration (combinational ready, registered pointer last_gnt, reset = 1):
  - FIFO full → both readies 0.
  - Only one valid → that client ready.
  - Both valid → client != last_gnt ready; the other 0.
  - last_gnt updates only on an actual transfer. At most one push per cycle.
- FIFO: circular, separate rd/wr pointers wrapping at 2**FIFO_AW; count width FIFO_AW+1, full = count == 2**FIFO_AW. Push and pop in the same cycle leave count unchanged. Order preserved across clients (acceptance order).
- Drain FSM states: IDLE, LAUNCH, SENDING, GAP.
  - IDLE: if count>0 → pop head into uart_din register, go LAUNCH.
  - LAUNCH: uart_en=1; timer counts. uart_tx_busy=1 → SENDING. Timer reaches LAUNCH_TO-1 without busy → set launch_err, byte dropped, go GAP.
  - SENDING: uart_en=0; wait uart_tx_busy=0 → GAP.
  - GAP: uart_en=0; count GAP_CYC cycles → IDLE.
- uart_en is registered and is 1 only in LAUNCH. uart_din is stable from entering LAUNCH until leaving SENDING.
- launch_err: set has priority over err_clr in the same cycle.

## Timing
- Reset values: s0_ready/s1_ready 0 (FIFO empty, no valid), uart_en 0, uart_din 0x00, fifo_count 0, idle 1, launch_err 0, FSM IDLE, pointers 0, last_gnt 1.
- Byte accepted at edge N → visible in fifo_count after N. FSM in IDLE pops at N+1; uart_en=1 and uart_din valid after N+1 edge.
- Serializer raises busy 2 cycles after uart_en rises; LAUNCH therefore lasts 2 cycles nominally; uart_en drops the cycle after busy is seen high.
- Minimum uart_en low time between launches: SENDING duration + GAP_CYC ≥ 2 cycles, guaranteeing a fresh rising edge per byte.
- Throughput: one byte per serializer frame + LAUNCH(2) + GAP_CYC + 1 (IDLE) cycles.
- Asynchronous reset mid-frame: all state to reset values immediately, FIFO contents discarded, uart_en 0; serializer completes its frame independently.
- busy already high on entering LAUNCH (should not occur): treated as acknowledge, go SENDING next cycle.

## Test plan
- Single byte 0xA5 on s0, busy model high 2 cycles after uart_en rise for 100 cycles → uart_en high exactly 2 cycles, uart_din=0xA5 throughout, idle returns 1 after busy falls + GAP_CYC + 1.
- s0 and s1 valid continuously with s0=0x10.., s1=0x20.. incrementing → FIFO order 0x10,0x20,0x11,0x21,…; s0 wins first tie.
- Fill 16 bytes with busy stuck high → fifo_count=16, both readies 0; release busy → one pop, ready reasserts, count never exceeds 16.
- Push and pop in same cycle at count=5 → count stays 5.
- Busy never rises → uart_en drops after LAUNCH_TO=16 cycles, launch_err=1, count decremented by 1; err_clr pulse → launch_err 0; simultaneous timeout+err_clr → launch_err 1.
- Assert sys_rst_n low during SENDING with count=3 → uart_en 0, fifo_count 0, idle 1, launch_err 0 immediately.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Two-client round-robin byte scheduler feeding a shared FIFO, drained one byte
// at a time into a UART serializer via its edge-triggered enable / busy handshake.
module uart_tx_sched #(
    parameter int unsigned FIFO_AW   = 4,
    parameter int unsigned LAUNCH_TO = 16,
    parameter int unsigned GAP_CYC   = 2
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               s0_valid,
    input  logic [7:0]         s0_data,
    output logic               s0_ready,
    input  logic               s1_valid,
    input  logic [7:0]         s1_data,
    output logic               s1_ready,
    input  logic               uart_tx_busy,
    input  logic               err_clr,
    output logic               uart_en,
    output logic [7:0]         uart_din,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               idle,
    output logic               launch_err
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned TW    = $clog2(LAUNCH_TO);
    localparam int unsigned GW    = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;

    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [TW-1:0]    TO_LAST  = TW'(LAUNCH_TO - 1);
    localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_SENDING,
        ST_GAP
    } state_e;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               last_gnt_q;
    state_e             state_q;
    logic [TW-1:0]      timer_q;
    logic [GW-1:0]      gap_q;
    logic               uart_en_q;
    logic [7:0]         uart_din_q;
    logic               err_q;

    logic               full, empty, gnt0, gnt1, push, pop, err_set;
    logic [7:0]         push_data;

    // Ties go to the client that did not win the last actual transfer.
    always_comb begin
        full      = (count_q == FULL_CNT);
        empty     = (count_q == '0);
        gnt0      = !full && s0_valid && (!s1_valid || last_gnt_q);
        gnt1      = !full && s1_valid && (!s0_valid || !last_gnt_q);
        push      = gnt0 || gnt1;
        push_data = gnt0 ? s0_data : s1_data;
        pop       = (state_q == ST_IDLE) && !empty;
        err_set   = (state_q == ST_LAUNCH) && !uart_tx_busy && (timer_q == TO_LAST);
        count_d   = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_gnt_q <= 1'b1;
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            gap_q      <= '0;
            uart_en_q  <= 1'b0;
            uart_din_q <= '0;
            err_q      <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q   <= wr_ptr_q + FIFO_AW'(1);
                last_gnt_q <= gnt1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);

            if (err_set)      err_q <= 1'b1;
            else if (err_clr) err_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        uart_din_q <= mem_q[rd_ptr_q];
                        uart_en_q  <= 1'b1;
                        timer_q    <= '0;
                        state_q    <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (uart_tx_busy) begin
                        uart_en_q <= 1'b0;
                        state_q   <= ST_SENDING;
                    end else if (timer_q == TO_LAST) begin
                        // No acknowledge: the byte is abandoned.
                        uart_en_q <= 1'b0;
                        gap_q     <= '0;
                        state_q   <= ST_GAP;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_SENDING: begin
                    if (!uart_tx_busy) begin
                        gap_q   <= '0;
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) state_q <= ST_IDLE;
                    else                   gap_q   <= gap_q + GW'(1);
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s0_ready   = gnt0;
    assign s1_ready   = gnt1;
    assign uart_en    = uart_en_q;
    assign uart_din   = uart_din_q;
    assign fifo_count = count_q;
    assign idle       = empty && (state_q == ST_IDLE);
    assign launch_err = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: arbitration vector table, byte scoreboard checked at each
// serializer launch, and directed sequences for full FIFO, timeout and async reset.
module tb_uart_tx_sched;

    localparam int DEPTH     = 16;
    localparam int LAUNCH_TO = 16;
    localparam int GAP_CYC   = 2;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       s0_valid = 1'b0, s1_valid = 1'b0;
    logic [7:0] s0_data = '0, s1_data = '0;
    logic       s0_ready, s1_ready;
    logic       uart_tx_busy = 1'b0;
    logic       err_clr = 1'b0;
    logic       uart_en;
    logic [7:0] uart_din;
    logic [4:0] fifo_count;
    logic       idle, launch_err;

    uart_tx_sched #(.FIFO_AW(4), .LAUNCH_TO(LAUNCH_TO), .GAP_CYC(GAP_CYC)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
        .uart_tx_busy(uart_tx_busy), .err_clr(err_clr),
        .uart_en(uart_en), .uart_din(uart_din), .fifo_count(fifo_count),
        .idle(idle), .launch_err(launch_err)
    );

    always #5 sys_clk = ~sys_clk;

    // Serializer model: busy rises one cycle after it sees an enable rising edge.
    typedef enum int {B_NORMAL, B_STUCK, B_NEVER} bmode_e;
    bmode_e bmode = B_NORMAL;
    int     frame_len = 100;
    int     frame_left = 0;
    bit     pend = 0;
    logic   en_prev = 1'b0;

    always @(negedge sys_clk) begin
        if (bmode == B_STUCK) begin
            uart_tx_busy = 1'b1;
        end else begin
            if (frame_left != 0) frame_left--;
            if (pend) begin
                frame_left = frame_len;
                pend = 0;
            end
            if (bmode == B_NORMAL && uart_en === 1'b1 && en_prev !== 1'b1) pend = 1;
            uart_tx_busy = (frame_left != 0);
        end
        en_prev = uart_en;
    end

    int         n_pass = 0, n_total = 0;
    logic [7:0] sb[$];
    logic [7:0] launched[$];
    int         model_count;
    logic       model_last;
    logic       prev_en;
    logic [7:0] cur_byte;
    logic       acc0, acc1, rose;
    int         en_hi_cnt;

    typedef struct {
        logic v0, v1;
        logic r0, r1;
    } arb_vec_t;
    arb_vec_t vec [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        s0_valid = 1'b0; s1_valid = 1'b0; err_clr = 1'b0;
        sb.delete(); launched.delete();
        model_count = 0; model_last = 1'b1; prev_en = 1'b0; cur_byte = '0;
        acc0 = 1'b0; acc1 = 1'b0; rose = 1'b0; en_hi_cnt = 0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
    endtask

    // One clock: check readies against the arbiter model, then update the
    // scoreboard from what the model says was accepted and what the DUT launched.
    task automatic tick();
        logic e0, e1, fl;
        #1;
        fl = (model_count == DEPTH);
        e0 = !fl && s0_valid && (!s1_valid || model_last);
        e1 = !fl && s1_valid && (!s0_valid || !model_last);
        check("s0_ready", 32'(s0_ready), 32'(e0));
        check("s1_ready", 32'(s1_ready), 32'(e1));
        @(posedge sys_clk);
        #1;
        rose = (uart_en === 1'b1) && (prev_en !== 1'b1);
        if (rose) begin
            if (sb.size() == 0) begin
                check("unexpected_launch", 32'(uart_en), 0);
            end else begin
                cur_byte = sb.pop_front();
                check("launch_din", 32'(uart_din), 32'(cur_byte));
                launched.push_back(uart_din);
                model_count--;
            end
        end else if (uart_en === 1'b1) begin
            check("din_stable", 32'(uart_din), 32'(cur_byte));
        end
        if (uart_en === 1'b1) en_hi_cnt++;
        acc0 = e0;
        acc1 = e1;
        if (e0) begin
            sb.push_back(s0_data); model_count++; model_last = 1'b0;
        end else if (e1) begin
            sb.push_back(s1_data); model_count++; model_last = 1'b1;
        end
        check("fifo_count", 32'(fifo_count), 32'(model_count));
        prev_en = uart_en;
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int n = 0;
        while (!(idle === 1'b1 && model_count == 0) && n < max_cyc) begin
            tick();
            n++;
        end
        check(name, 32'(idle), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_order [4];
        int n, pushed, t_since;
        bit seen, done;
        exp_order = '{8'h10, 8'h20, 8'h11, 8'h21};

        vec[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vec[1] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vec[2] = '{1'b1, 1'b1, 1'b0, 1'b1};
        vec[3] = '{1'b0, 1'b1, 1'b0, 1'b1};
        vec[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vec[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vec[6] = '{1'b0, 1'b1, 1'b0, 1'b1};
        vec[7] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vec[8] = '{1'b1, 1'b1, 1'b0, 1'b1};
        vec[9] = '{1'b0, 1'b0, 1'b0, 1'b0};

        // Reset values
        do_reset();
        check("rst_s0_ready", 32'(s0_ready), 0);
        check("rst_s1_ready", 32'(s1_ready), 0);
        check("rst_uart_en", 32'(uart_en), 0);
        check("rst_uart_din", 32'(uart_din), 0);
        check("rst_fifo_count", 32'(fifo_count), 0);
        check("rst_idle", 32'(idle), 1);
        check("rst_launch_err", 32'(launch_err), 0);

        // Arbitration table, serializer held busy so bytes accumulate
        bmode = B_STUCK;
        for (int i = 0; i < 10; i++) begin
            s0_valid = vec[i].v0; s0_data = 8'h80 + 8'(i);
            s1_valid = vec[i].v1; s1_data = 8'h90 + 8'(i);
            #1;
            check($sformatf("arb_r0_%0d", i), 32'(s0_ready), 32'(vec[i].r0));
            check($sformatf("arb_r1_%0d", i), 32'(s1_ready), 32'(vec[i].r1));
            tick();
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        bmode = B_NORMAL;
        frame_len = 100;
        do_reset();

        // Single byte 0xA5
        s0_valid = 1'b1; s0_data = 8'hA5;
        tick();
        s0_valid = 1'b0;
        seen = 0; t_since = 0; done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            tick();
            if (uart_en === 1'b1 || uart_tx_busy) check("a5_hold", 32'(uart_din), 'hA5);
            if (uart_tx_busy) begin
                seen = 1; t_since = 0;
            end else if (seen) begin
                t_since++;
                if (idle === 1'b1) done = 1;
            end
        end
        check("a5_idle", 32'(idle), 1);
        check("a5_en_cycles", 32'(en_hi_cnt), 2);
        check("a5_idle_delay", 32'(t_since), 32'(GAP_CYC + 1));

        // Both clients streaming: alternating acceptance order
        do_reset();
        frame_len = 4;
        s0_data = 8'h10; s1_data = 8'h20; s0_valid = 1'b1; s1_valid = 1'b1;
        pushed = 0;
        for (int i = 0; i < 40 && pushed < 12; i++) begin
            tick();
            if (acc0) begin s0_data++; pushed++; end
            if (acc1) begin s1_data++; pushed++; end
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        wait_idle(500, "order_drain");
        check("order_n", 32'(launched.size()), 12);
        for (int i = 0; i < 4; i++)
            check($sformatf("order_seq_%0d", i), 32'(launched[i]), 32'(exp_order[i]));

        // Fill to full with busy stuck, then release
        do_reset();
        bmode = B_STUCK;
        s0_data = 8'h30; s1_data = 8'hB0; s0_valid = 1'b1; s1_valid = 1'b1;
        for (int i = 0; i < 22; i++) begin
            tick();
            if (acc0) s0_data++;
            if (acc1) s1_data++;
        end
        #1;
        check("full_count", 32'(fifo_count), 16);
        check("full_r0", 32'(s0_ready), 0);
        check("full_r1", 32'(s1_ready), 0);
        bmode = B_NORMAL;
        frame_len = 4;
        n = 0;
        rose = 1'b0;
        while (!rose && n < 10) begin
            tick();
            if (acc0) s0_data++;
            if (acc1) s1_data++;
            n++;
        end
        check("refill_pop", 32'(uart_en), 1);
        check("refill_count", 32'(fifo_count), 15);
        #1;
        check("refill_ready", 32'(s0_ready | s1_ready), 1);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (acc0) s0_data++;
            if (acc1) s1_data++;
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        wait_idle(2000, "full_drain");

        // Push and pop in the same cycle at count 5
        do_reset();
        bmode = B_STUCK;
        s0_data = 8'h40; s0_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            s0_data++;
        end
        s0_valid = 1'b0;
        tick();
        check("pp_pre_count", 32'(fifo_count), 5);
        bmode = B_NORMAL;
        frame_len = 4;
        repeat (3) tick();
        s0_valid = 1'b1; s0_data = 8'h50;
        tick();
        s0_valid = 1'b0;
        check("pp_pop", 32'(uart_en), 1);
        check("pp_count", 32'(fifo_count), 5);
        wait_idle(500, "pp_drain");

        // Launch timeout, err_clr, and set-beats-clear
        do_reset();
        bmode = B_NEVER;
        s0_valid = 1'b1; s0_data = 8'h60;
        tick();
        s0_data = 8'h61;
        tick();
        s0_valid = 1'b0;
        check("to_err_before", 32'(launch_err), 0);
        n = 0;
        while (!(uart_en === 1'b0 && en_hi_cnt > 0) && n < 60) begin
            tick();
            n++;
        end
        check("to_en_cycles", 32'(en_hi_cnt), 32'(LAUNCH_TO));
        check("to_err_set", 32'(launch_err), 1);
        check("to_count", 32'(fifo_count), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", 32'(launch_err), 0);
        en_hi_cnt = 0;
        n = 0;
        while (en_hi_cnt < LAUNCH_TO && n < 60) begin
            tick();
            n++;
        end
        check("to2_err_pending", 32'(launch_err), 0);
        check("to2_en_still", 32'(uart_en), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_set_wins", 32'(launch_err), 1);
        check("to2_en_drop", 32'(uart_en), 0);
        check("to2_count", 32'(fifo_count), 0);

        // Asynchronous reset while SENDING with three bytes queued
        bmode = B_STUCK;
        s0_valid = 1'b1; s0_data = 8'h70;
        for (int i = 0; i < 4; i++) begin
            tick();
            s0_data++;
        end
        s0_valid = 1'b0;
        tick();
        check("arst_pre_count", 32'(fifo_count), 3);
        check("arst_pre_err", 32'(launch_err), 1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("arst_uart_en", 32'(uart_en), 0);
        check("arst_fifo_count", 32'(fifo_count), 0);
        check("arst_idle", 32'(idle), 1);
        check("arst_launch_err", 32'(launch_err), 0);
        check("arst_uart_din", 32'(uart_din), 0);
        bmode = B_NORMAL;
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
